// File: rtl/mil1553_tx_encoder.sv
// MIL-STD-1553 Manchester II word encoder: AXI-Stream word in, 40 half-bit frame out, back-to-back capable.
// Optional macro MIL1553_TX_TIMEOUT_EN adds a sticky fail-safe abort after 1320 continuous transmit half-bits.
module mil1553_tx_encoder #(
  parameter int clock_speed         = 2000000,
  parameter int mil1553_sample_rate = 2000000
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        tx0_1553,
  output logic        tx1_1553,
  output logic        en_tx_1553,
  output logic        busy,
  output logic        timeout
);

  localparam int DIV = clock_speed / mil1553_sample_rate;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_PARITY} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [5:0]    r_hb, w_hb_nxt, w_hb_inc;
  logic [15:0]   r_data;
  logic          r_cmd;
  logic          r_par;
  logic          r_rst_q;

  logic          w_tick;
  logic          w_last;
  logic          w_accept;
  logic          w_en;
  logic          w_tx0;
  logic          w_to_hit;
  logic          w_timeout;
  logic [3:0]    w_didx;

  assign w_tick   = (r_cnt == CW'(DIV - 1));
  assign w_last   = (r_state == S_PARITY) && (r_hb == 6'd39) && w_tick;
  assign w_accept = s_axis_tvalid && s_axis_tready;
  assign w_hb_inc = r_hb + 6'd1;
  assign w_en     = (r_state != S_IDLE);

  // r_rst_q keeps tready low while arst is held; it rises the cycle after release.
  assign s_axis_tready = ~r_rst_q && ~w_timeout && ((r_state == S_IDLE) || w_last);

  always_ff @(posedge aclk) begin
    if (arst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hb    <= '0;
      r_rst_q <= 1'b1;
      r_data  <= '0;
      r_cmd   <= 1'b0;
      r_par   <= 1'b0;
    end else begin
      r_rst_q <= 1'b0;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hb    <= w_hb_nxt;
      if (w_accept) begin
        r_data <= s_axis_tdata;
        r_cmd  <= s_axis_tuser;
        r_par  <= ~^s_axis_tdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hb_nxt    = r_hb;
    if (r_state != S_IDLE) begin
      if (!w_tick) begin
        w_cnt_nxt = r_cnt + CW'(1);
      end else if (w_last) begin
        w_cnt_nxt   = '0;
        w_hb_nxt    = '0;
        w_state_nxt = w_accept ? S_SYNC : S_IDLE;
      end else begin
        w_cnt_nxt = '0;
        w_hb_nxt  = w_hb_inc;
        if (w_hb_inc < 6'd6)       w_state_nxt = S_SYNC;
        else if (w_hb_inc < 6'd38) w_state_nxt = S_DATA;
        else                       w_state_nxt = S_PARITY;
      end
    end else if (w_accept) begin
      w_state_nxt = S_SYNC;
      w_cnt_nxt   = '0;
      w_hb_nxt    = '0;
    end
    if (w_to_hit) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_hb_nxt    = '0;
    end
  end

  // Data half-bits 6..37 map two-per-bit onto tdata[15] down to tdata[0].
  assign w_didx = 4'd15 - 4'(r_hb[5:1] - 5'd3);

  always_comb begin
    w_tx0 = 1'b0;
    case (r_state)
      S_SYNC:   w_tx0 = r_cmd ? (r_hb < 6'd3) : (r_hb >= 6'd3);
      S_DATA:   w_tx0 = r_data[w_didx] ^ r_hb[0];
      S_PARITY: w_tx0 = r_par ^ r_hb[0];
      default:  w_tx0 = 1'b0;
    endcase
  end

`ifdef MIL1553_TX_TIMEOUT_EN
  localparam logic [10:0] TO_LIMIT = 11'd1320;
  logic [10:0] r_tcnt;
  logic        r_timeout;

  assign w_to_hit  = w_en && w_tick && (r_tcnt == TO_LIMIT - 11'd1);
  assign w_timeout = r_timeout;

  always_ff @(posedge aclk) begin
    if (arst) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else if (w_to_hit) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b1;
    end else if (!w_en) begin
      r_tcnt <= '0;
    end else if (w_tick) begin
      r_tcnt <= r_tcnt + 11'd1;
    end
  end
`else
  assign w_to_hit  = 1'b0;
  assign w_timeout = 1'b0;
`endif

  assign tx0_1553   = w_tx0;
  assign tx1_1553   = w_en & ~w_tx0;
  assign en_tx_1553 = w_en;
  assign busy       = w_en;
  assign timeout    = w_timeout;

endmodule

// File: doc/mil1553_tx_encoder.md
MIL1553_TX_ENCODER -- requirements
Module: mil1553_tx_encoder

Interface
REQ-001 SHALL have parameter clock_speed, default 2000000: aclk frequency in Hz.
REQ-002 SHALL have parameter mil1553_sample_rate, default 2000000: half-bit rate in Hz; DIV = clock_speed/mil1553_sample_rate, an integer >= 1.
REQ-003 SHALL have port aclk  input  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port arst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port s_axis_tdata  input  16  word to transmit, MSB first.
REQ-006 SHALL have port s_axis_tuser  input  1  1 = command/status sync, 0 = data sync.
REQ-007 SHALL have port s_axis_tvalid  input  1  word valid.
REQ-008 SHALL have port s_axis_tready  output  1  encoder accepts word.
REQ-009 SHALL have port tx0_1553  output  1  true Manchester line drive.
REQ-010 SHALL have port tx1_1553  output  1  complement line drive.
REQ-011 SHALL have port en_tx_1553  output  1  transceiver enable.
REQ-012 SHALL have port busy  output  1  word in flight.
REQ-013 SHALL have port timeout  output  1  sticky fail-safe abort flag.

Function
REQ-014 SHALL run a half-bit counter 0..DIV-1; a tick occurs when the counter = DIV-1; the counter is cleared on every load.
REQ-015 SHALL implement states IDLE, SYNC, DATA and PARITY; the word frame is 40 half-bits, indexed 0..39.
REQ-016 SHALL accept a word when s_axis_tvalid=1 and s_axis_tready=1, registering tdata and tuser and computing odd parity over the 16 data bits.
REQ-017 SHALL assert s_axis_tready in IDLE, and also in the final cycle of half-bit 39, so that consecutive words are sent back to back.
REQ-018 SHALL enter SYNC on the cycle after acceptance and drive half-bit 0 from that cycle onward; each half-bit lasts exactly DIV cycles.
REQ-019 SHALL drive the SYNC tx0 pattern over half-bits 0-5 as 111000 for command/status and 000111 for data.
REQ-020 SHALL encode each DATA bit (half-bits 6-37) and the PARITY bit (half-bits 38-39) as 10 for a 1 and 01 for a 0.
REQ-021 SHALL hold tx1_1553 = ~tx0_1553 and en_tx_1553 = 1 in SYNC, DATA and PARITY.
REQ-022 SHALL hold tx0 = tx1 = 0 and en_tx_1553 = 0 in IDLE.
REQ-023 SHALL, after half-bit 39, return to IDLE if no word was accepted, or go straight to SYNC of the next word with no gap if one was accepted.
REQ-024 SHALL assert busy in every state except IDLE.

Reset
REQ-025 SHALL, on arst=1, drive outputs on the next edge to: state IDLE, counter 0, s_axis_tready=0, tx0_1553=0, tx1_1553=0, en_tx_1553=0, busy=0, timeout=0.
REQ-026 SHALL raise s_axis_tready on the first cycle after arst deasserts.
REQ-027 SHALL abort any word in flight when reset occurs mid-word, with no completion of the word.
REQ-028 SHALL give arst priority over a simultaneous handshake.

Configuration
REQ-029 SHALL, when macro MIL1553_TX_TIMEOUT_EN is defined, count ticks while en_tx_1553=1 and clear that count whenever en_tx_1553=0.
REQ-030 SHALL, with MIL1553_TX_TIMEOUT_EN defined, when the tick count reaches 1320 (660 us at the default rate), force IDLE outputs on the next cycle, set timeout=1, and hold s_axis_tready=0 until arst.
REQ-031 SHALL, without MIL1553_TX_TIMEOUT_EN, tie timeout to 0 and impose no limit on continuous transmission.

Verification
REQ-032 SHALL cover, with DIV=1, tuser=1 and tdata=0x0000: tx0 = 111000, then 01 x16, then 10; en high for exactly 40 cycles; tx1 = ~tx0 throughout.
REQ-033 SHALL cover, with DIV=1, tuser=0 and tdata=0xFFFF: tx0 = 000111, then 10 x16, then 10 (parity 1).
REQ-034 SHALL cover, with DIV=1 and tdata=0x0001: parity half-bits = 01; with DIV=2 the same word gives every level held for 2 cycles and en high for 80 cycles.
REQ-035 SHALL cover tvalid held high for 3 words: en stays high for 120 contiguous cycles, and tready pulses only in cycles 39 and 79 after the first acceptance.
REQ-036 SHALL cover arst asserted at half-bit 20: on the next edge all outputs are 0, and a new word afterwards starts with a clean sync.
REQ-037 SHALL cover, with MIL1553_TX_TIMEOUT_EN and continuous tvalid at DIV=1: en drops after 1320 cycles, timeout=1, tready stays 0 until arst; without the macro, transmission continues.
